regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter_if.sv | 24 ++
 rtl/regfile_wb_arbiter.sv | 85 ++++++++
 tb/tb_regfile_wb_arbiter.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - writeback requester and register-file write port bundle
interface regfile_wb_arbiter_if;
  logic        alu_valid;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        alu_stall;
  logic        md_valid;
  logic [4:0]  md_addr;
  logic [31:0] md_data;
  logic        md_ready;
  logic        write;
  logic [4:0]  in_address;
  logic [31:0] in_data;

  modport master (
    output alu_valid, alu_addr, alu_data, md_valid, md_addr, md_data,
    input  alu_stall, md_ready, write, in_address, in_data
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data, md_valid, md_addr, md_data,
    output alu_stall, md_ready, write, in_address, in_data
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register-file write-port arbiter between ALU and MUL/DIV results
// ALU wins by default; a MUL/DIV result blocked MAX_WAIT cycles forces one priority cycle.
module regfile_wb_arbiter #(
  parameter int MAX_WAIT = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  regfile_wb_arbiter_if.slave   rf_io
);
  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  typedef enum logic {NORMAL, MD_PRIO} state_e;

  state_e      state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic        write_q, write_d;
  logic [4:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        alu_grant;
  logic        md_xfer;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= NORMAL;
      wait_q  <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    wait_d          = wait_q;
    write_d         = 1'b0;
    addr_d          = addr_q;
    data_d          = data_q;
    rf_io.alu_stall = (state_q == MD_PRIO);
    rf_io.md_ready  = (state_q == MD_PRIO) ? 1'b1 : !rf_io.alu_valid;
    alu_grant       = (state_q == NORMAL) && rf_io.alu_valid;
    md_xfer         = rf_io.md_valid && rf_io.md_ready;

    // The counter only measures the current blocked MD result.
    if (!rf_io.md_valid || md_xfer) begin
      wait_d = '0;
    end else begin
      wait_d = wait_q + 4'd1;
    end

    case (state_q)
      NORMAL: begin
        if (rf_io.md_valid && !md_xfer && (wait_d == MAX_WAIT_C)) begin
          state_d = MD_PRIO;
        end
      end
      MD_PRIO: begin
        if (md_xfer || !rf_io.md_valid) begin
          state_d = NORMAL;
        end
      end
      default: state_d = NORMAL;
    endcase

    // Grants are mutually exclusive; x0 destinations complete silently.
    if (alu_grant && (rf_io.alu_addr != 5'd0)) begin
      write_d = 1'b1;
      addr_d  = rf_io.alu_addr;
      data_d  = rf_io.alu_data;
    end else if (md_xfer && (rf_io.md_addr != 5'd0)) begin
      write_d = 1'b1;
      addr_d  = rf_io.md_addr;
      data_d  = rf_io.md_data;
    end
  end

  assign rf_io.write      = write_q;
  assign rf_io.in_address = addr_q;
  assign rf_io.in_data    = data_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - scoreboard bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    int          c;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [4:0]  last_a = '0;
  logic [31:0] last_d = '0;

  regfile_wb_arbiter_if bus();

  regfile_wb_arbiter #(.MAX_WAIT(3)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .rf_io (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && bus.write === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: addr=%0d data=%0d cycle=%0d, required no write",
                 bus.in_address, bus.in_data, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.in_address !== mon_e.a || bus.in_data !== mon_e.d || cyc != mon_e.c) begin
          n_fail++;
          $display("FAIL write_check: got addr=%0d data=%0d cycle=%0d, required addr=%0d data=%0d cycle=%0d",
                   bus.in_address, bus.in_data, cyc, mon_e.a, mon_e.d, mon_e.c);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d, input int c);
    exp_q.push_back('{a: a, d: d, c: c});
    last_a = a;
    last_d = d;
  endtask

  task automatic drain(input string name);
    repeat (4) next_cycle();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d writes missing, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    bus.alu_valid = 1'b0; bus.alu_addr = '0; bus.alu_data = '0;
    bus.md_valid  = 1'b0; bus.md_addr  = '0; bus.md_data  = '0;
    rst = 1'b1;
    #2;
    n_checks++;
    if (bus.write !== 1'b0 || bus.in_address !== 5'd0 || bus.in_data !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: write=%b addr=%0d data=%0d, required 0 0 0",
               bus.write, bus.in_address, bus.in_data);
    end
    n_checks++;
    if (bus.alu_stall !== 1'b0 || bus.md_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_handshake: stall=%b md_ready=%b, required 0 1", bus.alu_stall, bus.md_ready);
    end
    bus.alu_valid = 1'b1;
    #1;
    n_checks++;
    if (bus.md_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_md_ready_alu: md_ready=%b, required 0", bus.md_ready);
    end
    bus.alu_valid = 1'b0;
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_alu_only();
    next_cycle();
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd1; bus.alu_data = 32'd10;
    push(5'd1, 32'd10, cyc + 1);
    @(negedge clk);
    n_checks++;
    if (bus.alu_stall !== 1'b0 || bus.md_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL alu_only_handshake: stall=%b md_ready=%b, required 0 0", bus.alu_stall, bus.md_ready);
    end
    next_cycle();
    bus.alu_valid = 1'b0;
    drain("alu_only");
  endtask

  task automatic test_x0();
    next_cycle();
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd0; bus.alu_data = 32'd55;
    next_cycle();
    bus.alu_valid = 1'b0;
    bus.md_valid = 1'b1; bus.md_addr = 5'd0; bus.md_data = 32'd77;
    @(negedge clk);
    n_checks++;
    if (bus.md_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL x0_md_ready: md_ready=%b, required 1", bus.md_ready);
    end
    next_cycle();
    bus.md_valid = 1'b0;
    repeat (2) next_cycle();
    n_checks++;
    if (bus.write !== 1'b0 || bus.in_address !== last_a || bus.in_data !== last_d) begin
      n_fail++;
      $display("FAIL x0_hold: write=%b addr=%0d data=%0d, required 0 %0d %0d",
               bus.write, bus.in_address, bus.in_data, last_a, last_d);
    end
    drain("x0");
  endtask

  task automatic test_md_only();
    next_cycle();
    bus.md_valid = 1'b1; bus.md_addr = 5'd5; bus.md_data = 32'd42;
    push(5'd5, 32'd42, cyc + 1);
    @(negedge clk);
    n_checks++;
    if (bus.md_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL md_only_ready: md_ready=%b, required 1", bus.md_ready);
    end
    next_cycle();
    bus.md_valid = 1'b0;
    drain("md_only");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      bus.alu_valid = 1'b1;
      bus.alu_addr  = 5'(2 + i);
      bus.alu_data  = 32'(20 + 10 * i);
      push(5'(2 + i), 32'(20 + 10 * i), cyc + 1);
    end
    next_cycle();
    bus.alu_valid = 1'b0;
    drain("back_to_back");
  endtask

  task automatic test_contention();
    for (int i = 0; i < 4; i++) begin
      if (i == 0) next_cycle();
      else next_cycle();
      bus.alu_valid = 1'b1;
      bus.alu_addr  = 5'(11 + i);
      bus.alu_data  = 32'(100 + i);
      bus.md_valid  = 1'b1; bus.md_addr = 5'd7; bus.md_data = 32'd99;
      if (i < 3) push(5'(11 + i), 32'(100 + i), cyc + 1);
      else       push(5'd7, 32'd99, cyc + 1);
      @(negedge clk);
      n_checks++;
      if (bus.alu_stall !== (i == 3) || bus.md_ready !== (i == 3)) begin
        n_fail++;
        $display("FAIL contention_cycle%0d: stall=%b md_ready=%b, required %b %b",
                 i, bus.alu_stall, bus.md_ready, (i == 3), (i == 3));
      end
    end
    next_cycle();
    bus.md_valid = 1'b0;
    push(5'd14, 32'd103, cyc + 1);
    @(negedge clk);
    n_checks++;
    if (bus.alu_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL contention_release: stall=%b, required 0", bus.alu_stall);
    end
    next_cycle();
    bus.alu_valid = 1'b0;
    drain("contention");
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      bus.alu_valid = 1'b1;
      bus.alu_addr  = 5'(21 + i);
      bus.alu_data  = 32'(300 + i);
      bus.md_valid  = 1'b1; bus.md_addr = 5'd9; bus.md_data = 32'd900;
      if (i < 3) push(5'(21 + i), 32'(300 + i), cyc + 1);
      @(negedge clk);
    end
    n_checks++;
    if (bus.alu_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_prio: stall=%b, required 1", bus.alu_stall);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.write !== 1'b0 || bus.in_address !== 5'd0 || bus.in_data !== 32'd0 || bus.alu_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: write=%b addr=%0d data=%0d stall=%b, required 0 0 0 0",
               bus.write, bus.in_address, bus.in_data, bus.alu_stall);
    end
    next_cycle();
    next_cycle();
    rst = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if (j > 0) next_cycle();
      bus.alu_addr = 5'(24 + j);
      bus.alu_data = 32'(200 + j);
      if (j < 3) push(5'(24 + j), 32'(200 + j), cyc + 1);
      else       push(5'd9, 32'd900, cyc + 1);
      @(negedge clk);
      n_checks++;
      if (bus.alu_stall !== (j == 3)) begin
        n_fail++;
        $display("FAIL reset_mid_restart%0d: stall=%b, required %b", j, bus.alu_stall, (j == 3));
      end
    end
    next_cycle();
    bus.md_valid = 1'b0;
    push(5'd27, 32'd203, cyc + 1);
    next_cycle();
    bus.alu_valid = 1'b0;
    drain("reset_mid");
  endtask

  initial begin
    test_reset();
    test_alu_only();
    test_x0();
    test_md_only();
    test_back_to_back();
    test_contention();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
